// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between the core data port and data memory. Core stores
// are queued in a DEPTH-entry circular FIFO and retired in order over a
// valid/ready write channel. Core loads are forwarded from the youngest
// buffered store to the same word, otherwise served from memory. The core
// only stalls on a store while the buffer is full.
//
// Optional build macro: STORE_BUFFER_COALESCE_EN
//   When defined, a store to a word that is already buffered overwrites the
//   youngest matching entry in place instead of allocating a new one (and so
//   never stalls). The head entry is excluded from this while it is being
//   handed to memory in the same cycle; such a store enqueues normally.
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, >= 2)
//   AW     address width
//   DW     data width
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset; discards all buffered stores
//   memwrite    core store request
//   memread     core load request
//   dataadr     core byte address (loads and stores)
//   writedata   core store data
//   readdata    load data to core (combinational)
//   stall       core must hold its store request this cycle
//   mem_wvalid  head entry presented to memory
//   mem_waddr   word-aligned address of the head entry
//   mem_wdata   data of the head entry
//   mem_wready  memory accepts the head entry this cycle
//   mem_raddr   memory read address (equals dataadr)
//   mem_rdata   memory read data, combinational with mem_raddr
//   count       number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic                   memread,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  output logic [DW-1:0]          readdata,
  output logic                   stall,
  output logic                   mem_wvalid,
  output logic [AW-1:0]          mem_waddr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_wready,
  output logic [AW-1:0]          mem_raddr,
  input  logic [DW-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage. Only the word address is kept; stores are word-only so
  // the low two address bits are always zero on the memory side.
  logic [AW-3:0] wa_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  // Pointer and occupancy state
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          coal;

  // Youngest-match search results
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] idx;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Address match against all valid entries.
  // Entries are walked oldest to youngest starting at head, so the last hit
  // wins and hit_idx ends up on the youngest matching entry. Validity is
  // derived from the occupancy count, which also means the head entry that is
  // being popped this cycle is still treated as valid. Loads and stores share
  // dataadr, so one search serves both forwarding and coalescing.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit     = 1'b0;
    hit_idx = head_q;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wa_q[idx] == dataadr[AW-1:2])) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel and enqueue control
  // ---------------------------------------------------------------------------
  assign mem_wvalid = !empty;
  assign mem_waddr  = {wa_q[head_q], 2'b00};
  assign mem_wdata  = data_q[head_q];
  assign pop        = mem_wvalid && mem_wready;

`ifdef STORE_BUFFER_COALESCE_EN
  // Merge into the youngest match, unless that match is the head entry that
  // memory is taking this very cycle; the youngest match can only be the head
  // when it is the sole match, so this is the "only match is head" case.
  assign coal = memwrite && hit && !((hit_idx == head_q) && pop);
`else
  assign coal = 1'b0;
`endif

  // The full flag is the registered occupancy, so a pop in this cycle does
  // not release the stall; the store is taken on the following cycle. This
  // keeps mem_wready out of the stall path.
  assign push  = memwrite && !coal && !full;
  assign stall = memwrite && !coal && full;

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  assign mem_raddr = dataadr;
  assign readdata  = (memread && hit) ? data_q[hit_idx] : mem_rdata;

  assign count = count_q;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state. DEPTH is a power of two, so the pointers
  // wrap from DEPTH-1 to 0 by natural overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: asynchronous reset empties the buffer immediately, which
  // drops mem_wvalid even in the middle of a handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: data only, no reset needed since validity comes from count.
  // push and coal are mutually exclusive.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[tail_q]   <= dataadr[AW-1:2];
      data_q[tail_q] <= writedata;
    end else if (coal) begin
      data_q[hit_idx] <= writedata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

`ifdef STORE_BUFFER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  // Expected occupancy in the table phase differs when repeated words merge
  localparam logic [2:0] C2 = COAL ? 3'd1 : 3'd2;
  localparam logic [2:0] C3 = COAL ? 3'd1 : 3'd3;

  logic          clk;
  logic          reset;
  logic          memwrite;
  logic          memread;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          stall;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .memread    (memread),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  // Memory writes the bench expects, in order
  wr_t exp_q[$];

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        exp_stall;
    logic [31:0] exp_rd;
    logic [2:0]  exp_cnt;
    logic        exp_wvld;
    logic [31:0] exp_waddr;
  } vec_t;

  vec_t tv[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Record an accepted store in the scoreboard. With coalescing, a store to a
  // word still waiting in the buffer replaces that write's data.
  function automatic void sb_store(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = {a[31:2], 2'b00};
    w.data = d;
    if (COAL) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].addr == w.addr) begin
          exp_q[i].data = d;
          return;
        end
      end
    end
    exp_q.push_back(w);
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic wr);
    memwrite   = we;
    memread    = re;
    dataadr    = a;
    writedata  = wd;
    mem_rdata  = rd;
    mem_wready = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (count != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    check(name, {29'd0, count}, 32'd0);
    check({name, "_sb_left"}, exp_q.size(), 32'd0);
  endtask

  // Memory-side monitor: a handshake seen mid-cycle completes at the next edge
  always @(negedge clk) begin : mon
    wr_t e;
    if (!reset && mem_wvalid && mem_wready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, want no write", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_waddr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 32'h84, 32'h7,  32'h0,    1'b0, 32'h0,    3'd0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 32'h84, 32'h9,  32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 32'h84};
    tv[2] = '{1'b0, 1'b1, 32'h84, 32'h0,  32'hDEAD, 1'b0, 32'h9,    C2,   1'b1, 32'h84};
    tv[3] = '{1'b0, 1'b1, 32'h88, 32'h0,  32'hDEAD, 1'b0, 32'hDEAD, C2,   1'b1, 32'h84};
    tv[4] = '{1'b1, 1'b0, 32'h86, 32'h33, 32'h5555, 1'b0, 32'h5555, C2,   1'b1, 32'h84};
    tv[5] = '{1'b0, 1'b1, 32'h85, 32'h0,  32'hBEEF, 1'b0, 32'h33,   C3,   1'b1, 32'h84};
    tv[6] = '{1'b0, 1'b1, 32'h90, 32'h0,  32'h1234, 1'b0, 32'h1234, C3,   1'b1, 32'h84};

    // Reset state, observed before the first clock edge
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h40, 32'h0, 32'hCAFE, 1'b0);
    #3;
    check("rst_count",  {29'd0, count}, 32'd0);
    check("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
    check("rst_stall",  {31'd0, stall}, 32'd0);
    check("rst_readdata", readdata, 32'hCAFE);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table phase: memory not ready, stores pile up and loads forward
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].we, tv[i].re, tv[i].adr, tv[i].wd, tv[i].rdata, 1'b0);
      if (tv[i].we) sb_store(tv[i].adr, tv[i].wd);
      #2;
      check($sformatf("tv%0d_stall", i), {31'd0, stall}, {31'd0, tv[i].exp_stall});
      check($sformatf("tv%0d_readdata", i), readdata, tv[i].exp_rd);
      check($sformatf("tv%0d_count", i), {29'd0, count}, {29'd0, tv[i].exp_cnt});
      check($sformatf("tv%0d_raddr", i), mem_raddr, tv[i].adr);
      check($sformatf("tv%0d_wvalid", i), {31'd0, mem_wvalid}, {31'd0, tv[i].exp_wvld});
      if (tv[i].exp_wvld) check($sformatf("tv%0d_waddr", i), mem_waddr, tv[i].exp_waddr);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_empty("tv_drain");

    // Two stores with memory always ready; first write presented next cycle
    drive(1'b1, 1'b0, 32'h80, 32'h5, 32'h0, 1'b1);
    sb_store(32'h80, 32'h5);
    #2;
    check("s1_stall_a", {31'd0, stall}, 32'd0);
    check("s1_wvalid_empty", {31'd0, mem_wvalid}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h84, 32'h7, 32'h0, 1'b1);
    sb_store(32'h84, 32'h7);
    #2;
    check("s1_stall_b", {31'd0, stall}, 32'd0);
    check("s1_wvalid", {31'd0, mem_wvalid}, 32'd1);
    check("s1_waddr", mem_waddr, 32'h80);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    #2;
    check("s1_count_pushpop", {29'd0, count}, 32'd1);
    wait_empty("s1_drain");

    // Fill to full, fifth store stalls until one cycle after the first pop
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'(4 * k), 32'h10 + 32'(k), 32'h0, 1'b0);
      sb_store(32'(4 * k), 32'h10 + 32'(k));
      #2;
      check($sformatf("s2_stall%0d", k), {31'd0, stall}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h10, 32'h14, 32'h0, 1'b0);
    #2;
    check("s2_count_full", {29'd0, count}, 32'd4);
    check("s2_stall_full", {31'd0, stall}, 32'd1);
    tick();
    check("s2_stall_hold", {31'd0, stall}, 32'd1);
    mem_wready = 1'b1;
    #1;
    check("s2_stall_popcycle", {31'd0, stall}, 32'd1);
    tick();
    #1;
    check("s2_stall_release", {31'd0, stall}, 32'd0);
    check("s2_count_after_pop", {29'd0, count}, 32'd3);
    sb_store(32'h10, 32'h14);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    #2;
    check("s2_count_pushpop", {29'd0, count}, 32'd3);
    wait_empty("s2_drain");

    // Reset while a write is mid-handshake discards everything at once
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h20 + 32'(k), 32'h0, 1'b0);
      sb_store(32'h100 + 32'(4 * k), 32'h20 + 32'(k));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    check("s3_count3", {29'd0, count}, 32'd3);
    check("s3_wvalid1", {31'd0, mem_wvalid}, 32'd1);
    tick();
    mem_wready = 1'b1;
    reset = 1'b1;
    #2;
    check("s3_rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
    check("s3_rst_count", {29'd0, count}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("s3_quiet%0d", k), {31'd0, mem_wvalid}, 32'd0);
    end
    mem_wready = 1'b0;

    // Repeated store to one word: merged or queued depending on build
    drive(1'b1, 1'b0, 32'h80, 32'h1, 32'h0, 1'b0);
    sb_store(32'h80, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h80, 32'h2, 32'h0, 1'b0);
    sb_store(32'h80, 32'h2);
    #2;
    check("s4_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    check("s4_count", {29'd0, count}, COAL ? 32'd1 : 32'd2);
    mem_wready = 1'b1;
    wait_empty("s4_drain");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
